// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Serializes one byte per accepted tx_start into an asynchronous frame:
//   start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
//
// Parameters
//   CLK_FREQUENCY  system clock in Hz
//   BAUD_RATE      serial bit rate; bit period = CLK_FREQUENCY / BAUD_RATE
//   PARITY         0 none, 1 even, 2 odd
//   STOP_BITS      1 or 2
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous, active-low
//   tx_start  transmit request, only looked at while idle
//   tx_data   byte to send, captured on the accept edge
//   tx_busy   high from the cycle after accept to the end of the last stop bit
//   tx_done   one-cycle pulse when the frame completes
//   tx        registered serial line, idles high
module uart_tx_serializer #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int BAUD_DIV = CLK_FREQUENCY / BAUD_RATE;
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  if (BAUD_DIV < 2) begin : g_bad_div
    $error("uart_tx_serializer: BAUD_DIV must be >= 2");
  end
  if (PARITY != 0 && PARITY != 1 && PARITY != 2) begin : g_bad_parity
    $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic            par_q, par_d;
  logic            stop_q, stop_d;
  logic            tx_d, busy_d, done_d;
  logic            wrap;

  assign wrap = (cnt_q == CW'(BAUD_DIV - 1));

  // State and datapath registers. Outputs are registered from the
  // next-state values so the line changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tx      <= tx_d;
      tx_busy <= busy_d;
      tx_done <= done_d;
    end
  end

  // Next state plus bit timer / shifter / counters.
  always_comb begin
    state_d = state_q;
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;
    stop_d  = stop_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (tx_start) begin
          state_d = S_START;
          sh_d    = tx_data;
          // Even parity is the XOR of the byte; odd is its complement.
          par_d   = (^tx_data) ^ (PARITY == 2);
          idx_d   = '0;
          stop_d  = 1'b0;
        end
      end
      S_START: if (wrap) state_d = S_DATA;
      S_DATA: begin
        if (wrap) begin
          // Shifter always presents the current bit at sh[0].
          sh_d = sh_q >> 1;
          if (idx_q == 3'd7) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_PARITY: if (wrap) state_d = S_STOP;
      S_STOP: begin
        if (wrap) begin
          if (stop_q == 1'(STOP_BITS - 1)) state_d = S_IDLE;
          else                             stop_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode, evaluated on the state being entered.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = sh_d[0];
      S_PARITY: tx_d = par_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer. Four instances with BAUD_DIV = 10 cover
// the configurations {none,1 stop}, {even,1}, {odd,1}, {even,2}. A frame-level
// reference model checks every instance every cycle; a vector table and a few
// hand sequences check frames against hand-derived bit patterns.
module tb_uart_tx_serializer;
  localparam int D  = 10;
  localparam int NI = 4;

  function automatic int cfg_par(int g);
    return (g == 1 || g == 3) ? 1 : (g == 2) ? 2 : 0;
  endfunction
  function automatic int cfg_stop(int g);
    return (g == 3) ? 2 : 1;
  endfunction
  function automatic int frame_len(int c);
    return 9 + ((cfg_par(c) != 0) ? 1 : 0) + cfg_stop(c);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst_i, start_i;
  logic [7:0]    data_i [NI];
  wire  [NI-1:0] tx_o, busy_o, done_o;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_serializer #(
      .CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000),
      .PARITY(cfg_par(g)), .STOP_BITS(cfg_stop(g))
    ) u_dut (
      .clk(clk), .reset(rst_i[g]), .tx_start(start_i[g]), .tx_data(data_i[g]),
      .tx_busy(busy_o[g]), .tx_done(done_o[g]), .tx(tx_o[g])
    );
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of line levels; the line shows level
  // (elapsed / D) while elapsed < len*D, then done pulses for one cycle.
  logic        m_act  [NI];
  logic        m_done [NI];
  int          m_e    [NI];
  int          m_len  [NI];
  logic [11:0] m_frame[NI];

  function automatic logic [11:0] build(int c, logic [7:0] d);
    logic [11:0] f;
    logic pb;
    f = '1;
    f[0] = 1'b0;
    for (int j = 0; j < 8; j++) f[1+j] = d[j];
    if (cfg_par(c) != 0) begin
      pb = ($countones(d) % 2) == 1;
      if (cfg_par(c) == 2) pb = !pb;
      f[9] = pb;
    end
    return f;
  endfunction

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      if (!rst_i[i]) begin
        m_act[i] = 1'b0; m_done[i] = 1'b0;
      end else if (m_act[i]) begin
        m_e[i]++;
        m_done[i] = 1'b0;
        if (m_e[i] == m_len[i] * D) begin
          m_act[i] = 1'b0; m_done[i] = 1'b1;
        end
      end else begin
        m_done[i] = 1'b0;
        if (start_i[i]) begin
          m_act[i] = 1'b1; m_e[i] = 0;
          m_len[i] = frame_len(i); m_frame[i] = build(i, data_i[i]);
        end
      end
    end
  endtask

  // One clock: inputs are applied before posedge, outputs compared at negedge.
  task automatic tick();
    logic etx;
    @(posedge clk);
    @(negedge clk);
    model_step();
    for (int i = 0; i < NI; i++) begin
      etx = m_act[i] ? m_frame[i][m_e[i] / D] : 1'b1;
      chk($sformatf("model_tx[%0d]", i), 32'(tx_o[i]), 32'(etx));
      chk($sformatf("model_busy[%0d]", i), 32'(busy_o[i]), 32'(m_act[i]));
      chk($sformatf("model_done[%0d]", i), 32'(done_o[i]), 32'(m_done[i]));
    end
  endtask

  // Watch a frame already accepted (current cycle = first cycle of start bit).
  // Optional noise: from cycle 35 re-request with changing data until shortly
  // before the frame would end.
  task automatic watch_frame(input int c, input bit noisy, output logic [11:0] got,
                             output int bcnt, output int dat);
    int len;
    len = frame_len(c);
    got = '1; bcnt = 0; dat = -1;
    for (int t = 0; t < 200 && dat < 0; t++) begin
      if (busy_o[c]) bcnt++;
      if (t < len * D && t % D == D / 2) got[t / D] = tx_o[c];
      if (done_o[c]) dat = t;
      if (noisy) begin
        start_i[c] = (t >= 34 && t < 97);
        data_i[c]  = (t == 34) ? 8'hFF : 8'($urandom);
      end
      tick();
    end
    start_i[c] = 1'b0;
  endtask

  task automatic run_frame(input int c, input logic [7:0] d, input bit noisy,
                           output logic [11:0] got, output int bcnt, output int dat);
    data_i[c] = d; start_i[c] = 1'b1;
    tick();
    start_i[c] = 1'b0;
    watch_frame(c, noisy, got, bcnt, dat);
  endtask

  typedef struct {
    int          c;
    logic [7:0]  d;
    int          len;
    logic [11:0] frame;
  } vec_t;

  vec_t        tbl [8];
  logic [11:0] got, mask;
  int          bcnt, dat, gap, seen;

  initial begin
    tbl[0] = '{0, 8'hA5, 10, {2'b00, 1'b1, 8'hA5, 1'b0}};
    tbl[1] = '{1, 8'h07, 11, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}};
    tbl[2] = '{2, 8'h07, 11, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}};
    tbl[3] = '{3, 8'h07, 12, {2'b11, 1'b1, 8'h07, 1'b0}};
    tbl[4] = '{1, 8'hFF, 11, {1'b0, 1'b1, 1'b0, 8'hFF, 1'b0}};
    tbl[5] = '{2, 8'h00, 11, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}};
    tbl[6] = '{3, 8'h80, 12, {2'b11, 1'b1, 8'h80, 1'b0}};
    tbl[7] = '{0, 8'h00, 10, {2'b00, 1'b1, 8'h00, 1'b0}};

    for (int i = 0; i < NI; i++) begin
      m_act[i] = 1'b0; m_done[i] = 1'b0; m_e[i] = 0; m_len[i] = 0; m_frame[i] = '1;
      data_i[i] = 8'hA5;
    end

    // Reset held 3 cycles with a pending request: nothing starts.
    rst_i = '0; start_i = '1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("reset_tx", 32'(tx_o), 32'(4'hF));
      chk("reset_busy", 32'(busy_o), 32'd0);
    end
    rst_i = '1; start_i = '0;
    tick(); tick();

    // Vector table: line pattern sampled mid-bit, busy length, done position.
    for (int k = 0; k < 8; k++) begin
      run_frame(tbl[k].c, tbl[k].d, 1'b0, got, bcnt, dat);
      mask = 12'((1 << tbl[k].len) - 1);
      chk($sformatf("tbl%0d_bits", k), 32'(got & mask), 32'(tbl[k].frame & mask));
      chk($sformatf("tbl%0d_busy", k), bcnt, tbl[k].len * D);
      chk($sformatf("tbl%0d_done", k), dat, tbl[k].len * D);
      tick();
    end

    // Requests and data changes during a frame are ignored.
    run_frame(0, 8'h3C, 1'b1, got, bcnt, dat);
    chk("noisy_bits", 32'(got & 12'h3FF), 32'({1'b1, 8'h3C, 1'b0}));
    chk("noisy_busy", bcnt, 100);
    chk("noisy_done", dat, 100);
    for (int k = 0; k < 5; k++) begin
      chk("noisy_no_restart", 32'(busy_o[0]), 32'd0);
      tick();
    end

    // Back-to-back: request in the done cycle.
    data_i[0] = 8'h12; start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    for (int t = 0; t < 150 && !done_o[0]; t++) tick();
    chk("b2b_done_seen", 32'(done_o[0]), 32'd1);
    gap = busy_o[0] ? 0 : 1;
    data_i[0] = 8'h55; start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    chk("b2b_gap", gap, 1);
    chk("b2b_tx_fall", 32'(tx_o[0]), 32'd0);
    chk("b2b_busy", 32'(busy_o[0]), 32'd1);
    watch_frame(0, 1'b0, got, bcnt, dat);
    chk("b2b_bits", 32'(got & 12'h3FF), 32'({1'b1, 8'h55, 1'b0}));
    chk("b2b_busy_len", bcnt, 100);
    chk("b2b_done", dat, 100);

    // Reset mid-frame aborts without a done pulse; next frame is clean.
    tick();
    data_i[0] = 8'hF0; start_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    for (int t = 0; t < 45; t++) tick();
    rst_i[0] = 1'b0;
    tick();
    rst_i[0] = 1'b1;
    chk("abort_tx", 32'(tx_o[0]), 32'd1);
    chk("abort_busy", 32'(busy_o[0]), 32'd0);
    seen = 0;
    for (int t = 0; t < 110; t++) begin
      if (done_o[0] || busy_o[0]) seen = 1;
      tick();
    end
    chk("abort_quiet", seen, 0);
    run_frame(0, 8'h81, 1'b0, got, bcnt, dat);
    chk("after_abort_bits", 32'(got & 12'h3FF), 32'({1'b1, 8'h81, 1'b0}));
    chk("after_abort_busy", bcnt, 100);
    chk("after_abort_done", dat, 100);

    // Random traffic on all instances against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NI; i++) begin
        rst_i[i]   = ($urandom_range(0, 399) != 0);
        start_i[i] = ($urandom_range(0, 5) == 0);
        data_i[i]  = 8'($urandom);
      end
      tick();
    end
    rst_i = '1; start_i = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
